// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_t           loader FSM states
//   HALT_WORD_DEFAULT word value that terminates a load
//   IMEM_BYTES        instruction memory size in bytes
//   WORD_BYTES        bytes per instruction word
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int unsigned IMEM_BYTES        = 256;
    localparam int unsigned WORD_BYTES        = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: byte index counter and little-endian word assembly.
//   clk, reset  system clock, synchronous active-high reset
//   clear       drop any partial word and restart at lane 0
//   accept      a byte is taken this cycle
//   data        the byte being taken
//   partial     at least one byte of the current word is held
//   word_ready  the byte taken this cycle completes a word
//   word        assembled word, valid while word_ready is high
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic        partial,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] low_lanes;

    // Lane 3 is never stored: it arrives together with word_ready and is
    // combined directly, so the caller captures the word in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx  <= '0;
            low_lanes <= '0;
        end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    low_lanes[7:0]   <= data;
                2'd1:    low_lanes[15:8]  <= data;
                2'd2:    low_lanes[23:16] <= data;
                default: ;
            endcase
        end
    end

    assign partial    = (byte_idx != 2'd0);
    assign word_ready = accept && (byte_idx == 2'd3);
    assign word       = {data, low_lanes};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: assembles a byte stream into 32-bit words and writes them to
// consecutive instruction-memory addresses, stopping on a halt word or when
// the memory is full.
//   clk, reset     system clock, synchronous active-high reset
//   start          pulse; begins a load at address 0 (ignored while busy)
//   rx_data/valid  incoming byte stream; rx_ready accepts a byte
//   imem_wr_*      memory write port; data/addr hold outside the strobe
//   busy           load in progress
//   done           load finished on the halt word
//   error          memory overflow or inter-byte timeout
//   word_count     words written in the current load
// Optional: define IMEM_LOADER_TIMEOUT_EN to abort a load when a partial
// word sees no new byte for TIMEOUT_CYCLES cycles.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter logic [31:0] HALT_WORD      = HALT_WORD_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_wr_en,
    output logic [31:0]       imem_wr_data,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-2:0] word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_BYTES - WORD_BYTES);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              load_start;
    logic              partial;
    logic              word_ready;
    logic [31:0]       word;
    logic              timeout;

    // Reset gates the handshake and strobe so nothing moves in the reset cycle.
    assign rx_ready   = (state == RECV) && !reset;
    assign imem_wr_en = (state == WRITE) && !reset;
    assign busy       = (state == RECV) || (state == WRITE);
    assign done       = (state == DONE);
    assign error      = (state == ERR);
    assign accept     = rx_ready && rx_valid;
    assign load_start = start && (state == IDLE || state == DONE || state == ERR);

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_start || timeout),
        .accept     (accept),
        .data       (rx_data),
        .partial    (partial),
        .word_ready (word_ready),
        .word       (word)
    );

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] idle_cycles;

    always_ff @(posedge clk) begin
        if (reset || state != RECV || !partial || accept) begin
            idle_cycles <= '0;
        end else begin
            idle_cycles <= idle_cycles + TO_W'(1);
        end
    end

    assign timeout = (state == RECV) && partial && !accept &&
                     (idle_cycles == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the feature a partial word waits forever; this term is always 0.
    assign timeout = 1'b0 & partial & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = RECV;
            RECV: begin
                if (timeout)         state_next = ERR;
                else if (word_ready) state_next = WRITE;
            end
            WRITE: begin
                if (imem_wr_data == HALT_WORD) state_next = DONE;
                else if (addr == LAST_ADDR)    state_next = ERR;
                else                           state_next = RECV;
            end
            DONE:    if (start) state_next = RECV;
            ERR:     if (start) state_next = RECV;
            default: state_next = IDLE;
        endcase
    end

    // The write port registers are loaded as the last byte arrives, so they
    // are valid during WRITE and then hold while the next word assembles.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr         <= '0;
            word_count   <= '0;
            imem_wr_data <= '0;
            imem_wr_addr <= '0;
        end else begin
            if (load_start) begin
                addr       <= '0;
                word_count <= '0;
            end
            if (word_ready) begin
                imem_wr_data <= word;
                imem_wr_addr <= addr;
            end
            if (state == WRITE) begin
                addr       <= addr + ADDR_W'(WORD_BYTES);
                word_count <= word_count + (ADDR_W-1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Define IMEM_LOADER_TIMEOUT_EN to also exercise the inter-byte timeout.
module tb_imem_loader;

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 16;
`else
    localparam int unsigned TB_TIMEOUT = 1_000_000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_wr_en;
    logic [31:0] imem_wr_data;
    logic [7:0]  imem_wr_addr;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  word_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] wq_data[$];
    logic [7:0]  wq_addr[$];

    imem_loader #(
        .ADDR_W         (8),
        .HALT_WORD      (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_data (imem_wr_data),
        .imem_wr_addr (imem_wr_addr),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    // Record every write strobe shortly after the edge that raised it.
    always @(posedge clk) begin
        #1;
        if (imem_wr_en) begin
            wq_data.push_back(imem_wr_data);
            wq_addr.push_back(imem_wr_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wq_data.delete();
        wq_addr.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Leaves rx_valid high; callers drop it or present the next byte.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            check("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
            rx_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] w;
        int unsigned n;
        int unsigned cycles;
        int unsigned ready_hits;
        logic        ready_seen;
        logic [7:0]  stream[32];

        // Reset state
        @(negedge clk);
        do_reset();
        check("rst_busy",  {31'b0, busy}, 32'd0);
        check("rst_done",  {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_ready", {31'b0, rx_ready}, 32'd0);
        check("rst_wr_en", {31'b0, imem_wr_en}, 32'd0);
        check("rst_data",  imem_wr_data, 32'd0);
        check("rst_addr",  {24'b0, imem_wr_addr}, 32'd0);
        check("rst_wc",    {25'b0, word_count}, 32'd0);

        // Single word, write strobe in the cycle after the 4th byte
        pulse_start();
        check("t1_busy", {31'b0, busy}, 32'd1);
        send_word(32'h2010_0013);
        check("t1_latency", {31'b0, imem_wr_en}, 32'd1);
        check("t1_wr_ready", {31'b0, rx_ready}, 32'd0);
        @(negedge clk);
        check("t1_count", wq_data.size(), 32'd1);
        if (wq_data.size() >= 1) begin
            check("t1_data", wq_data[0], 32'h2010_0013);
            check("t1_addr", {24'b0, wq_addr[0]}, 32'd0);
        end
        check("t1_wc",    {25'b0, word_count}, 32'd1);
        check("t1_recv",  {31'b0, rx_ready}, 32'd1);
        check("t1_hold",  imem_wr_data, 32'h2010_0013);
        // start while busy must not restart the address
        pulse_start();
        send_word(32'hDEAD_BEEF);
        @(negedge clk);
        check("t1b_count", wq_data.size(), 32'd2);
        if (wq_data.size() >= 2) begin
            check("t1b_addr", {24'b0, wq_addr[1]}, 32'd4);
            check("t1b_data", wq_data[1], 32'hDEAD_BEEF);
        end
        check("t1b_wc", {25'b0, word_count}, 32'd2);

        // Three words then the halt word
        do_reset();
        pulse_start();
        send_word(32'h0000_0001);
        send_word(32'h1234_5678);
        send_word(32'hFFFF_FFFE);
        send_word(32'hFFFF_FFFF);
        @(negedge clk);
        check("t2_count", wq_data.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wq_addr.size()) check("t2_addr", {24'b0, wq_addr[i]}, 32'(4 * i));
        end
        if (wq_data.size() == 4) check("t2_halt_data", wq_data[3], 32'hFFFF_FFFF);
        check("t2_done",  {31'b0, done}, 32'd1);
        check("t2_busy",  {31'b0, busy}, 32'd0);
        check("t2_error", {31'b0, error}, 32'd0);
        check("t2_wc",    {25'b0, word_count}, 32'd4);

        // Overflow: 64 words fill memory, the 65th is refused
        do_reset();
        pulse_start();
        for (int i = 0; i < 64; i++) send_word(32'h1000_0000 | 32'(i));
        @(negedge clk);
        check("t3_count", wq_data.size(), 32'd64);
        if (wq_data.size() == 64) begin
            check("t3_last_addr", {24'b0, wq_addr[63]}, 32'd252);
            check("t3_last_data", wq_data[63], 32'h1000_003F);
        end
        check("t3_error", {31'b0, error}, 32'd1);
        check("t3_done",  {31'b0, done}, 32'd0);
        check("t3_busy",  {31'b0, busy}, 32'd0);
        check("t3_wc",    {25'b0, word_count}, 32'd64);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        ready_hits = 0;
        for (int i = 0; i < 6; i++) begin
            if (rx_ready) ready_hits++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check("t3_refused", ready_hits, 32'd0);
        check("t3_no_write", wq_data.size(), 32'd64);

        // Halt word at the last address ends in DONE, not ERR
        do_reset();
        pulse_start();
        for (int i = 0; i < 63; i++) send_word(32'h2000_0000 | 32'(i));
        send_word(32'hFFFF_FFFF);
        @(negedge clk);
        check("t3b_done",  {31'b0, done}, 32'd1);
        check("t3b_error", {31'b0, error}, 32'd0);
        if (wq_addr.size() == 64) check("t3b_addr", {24'b0, wq_addr[63]}, 32'd252);

        // Reset mid-word discards the partial word
        do_reset();
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        rx_valid = 1'b0;
        do_reset();
        pulse_start();
        send_word(32'hDDCC_BBAA);
        @(negedge clk);
        check("t4_count", wq_data.size(), 32'd1);
        if (wq_data.size() >= 1) begin
            check("t4_data", wq_data[0], 32'hDDCC_BBAA);
            check("t4_addr", {24'b0, wq_addr[0]}, 32'd0);
        end

        // rx_valid held high across 8 words
        do_reset();
        pulse_start();
        for (int i = 0; i < 32; i++) stream[i] = 8'(i * 7 + 3);
        n = 0;
        cycles = 0;
        rx_valid = 1'b1;
        rx_data  = stream[0];
        while (n < 32 && cycles < 400) begin
            ready_seen = rx_ready;
            if (imem_wr_en) check("t5_ready_in_write", {31'b0, rx_ready}, 32'd0);
            @(negedge clk);
            cycles++;
            if (ready_seen) n++;
            if (n < 32) rx_data = stream[n];
        end
        rx_valid = 1'b0;
        check("t5_bytes", n, 32'd32);
        repeat (2) @(negedge clk);
        check("t5_count", wq_data.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            w = {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
            if (i < wq_data.size()) begin
                check("t5_data", wq_data[i], w);
                check("t5_addr", {24'b0, wq_addr[i]}, 32'(4 * i));
            end
        end
        check("t5_wc", {25'b0, word_count}, 32'd8);

`ifdef IMEM_LOADER_TIMEOUT_EN
        // One byte then silence: error after 16 cycles, no write
        do_reset();
        pulse_start();
        send_byte(8'h77);
        rx_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("t6_no_err_yet", {31'b0, error}, 32'd0);
        @(negedge clk);
        check("t6_error", {31'b0, error}, 32'd1);
        check("t6_no_write", wq_data.size(), 32'd0);
        pulse_start();
        send_word(32'h0403_0201);
        @(negedge clk);
        check("t6_count", wq_data.size(), 32'd1);
        if (wq_data.size() >= 1) begin
            check("t6_data", wq_data[0], 32'h0403_0201);
            check("t6_addr", {24'b0, wq_addr[0]}, 32'd0);
        end
`endif

        b = 8'h00;
        if (b != 8'h00) $display("unreachable");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
